// File: rtl/channel_in_acc_tree.sv
// Per-lane reduction of CH_IN channel products through a registered binary adder tree,
// followed by a saturating accumulator that sums successive beats into one result per group.
module channel_in_acc_tree #(
  parameter int CH_IN     = 16,
  parameter int LANES     = 8,
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [LANES*CH_IN*WIDTH_IN-1:0] data_in,
  output logic                          out_valid,
  output logic [LANES*WIDTH_OUT-1:0]    data_out,
  output logic [LANES-1:0]              out_sat
);

  localparam int S  = $clog2(CH_IN);
  localparam int TW = WIDTH_IN + S + 1;

  // Stage 0: registered input channels.
  logic signed [WIDTH_IN-1:0] ch_reg [CH_IN][LANES];

  // NOTE: datapath registers carry no reset; only the valid/flag pipeline does,
  // so stale data is never observed and the wide registers stay reset-free.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_IN; c++) begin
      for (int p = 0; p < LANES; p++) begin
        ch_reg[c][p] <= data_in[(c*LANES+p)*WIDTH_IN +: WIDTH_IN];
      end
    end
  end

  for (genvar s = 1; s <= S; s++) begin : g_stage
    localparam int NW = WIDTH_IN + s + 1;
    localparam int PW = (s == 1) ? WIDTH_IN : WIDTH_IN + s;
    localparam int NN = CH_IN >> s;

    logic signed [PW-1:0] prev [2*NN][LANES];
    logic signed [NW-1:0] node [NN][LANES];

    for (genvar i = 0; i < 2*NN; i++) begin : g_prev
      for (genvar p = 0; p < LANES; p++) begin : g_lane
        if (s == 1) begin : g_in
          assign prev[i][p] = ch_reg[i][p];
        end else begin : g_mid
          assign prev[i][p] = g_stage[s-1].node[i][p];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < NN; i++) begin
        for (int p = 0; p < LANES; p++) begin
          node[i][p] <= NW'(prev[2*i][p]) + NW'(prev[2*i+1][p]);
        end
      end
    end
  end

  logic signed [TW-1:0] tree_sum [LANES];
  for (genvar p = 0; p < LANES; p++) begin : g_root
    assign tree_sum[p] = g_stage[S].node[0][p];
  end

  // Control flags run one slot per data register, stage 0 through stage S.
  logic [S:0] vld_pipe;
  logic [S:0] first_pipe;
  logic [S:0] last_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[S-1:0],   in_valid};
      first_pipe <= {first_pipe[S-1:0], in_valid & in_first};
      last_pipe  <= {last_pipe[S-1:0],  in_valid & in_last};
    end
  end

  logic signed [WIDTH_OUT-1:0] acc      [LANES];
  logic signed [WIDTH_OUT-1:0] next_acc [LANES];
  logic signed [WIDTH_OUT:0]   sum_wide [LANES];
  logic [LANES-1:0]            acc_sat;
  logic [LANES-1:0]            next_sat;
  logic                        grp_open;
  logic                        start;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    start    = first_pipe[S] || !grp_open;
    next_sat = acc_sat;
    for (int p = 0; p < LANES; p++) begin
      // One extra bit of headroom: the sum of two in-range values cannot wrap here.
      sum_wide[p] = (WIDTH_OUT+1)'(acc[p]) + (WIDTH_OUT+1)'(tree_sum[p]);
      next_acc[p] = sum_wide[p][WIDTH_OUT-1:0];
      if (start) begin
        next_acc[p] = WIDTH_OUT'(tree_sum[p]);
        next_sat[p] = 1'b0;
      end else if (sum_wide[p][WIDTH_OUT] != sum_wide[p][WIDTH_OUT-1]) begin
        next_acc[p] = {sum_wide[p][WIDTH_OUT], {(WIDTH_OUT-1){~sum_wide[p][WIDTH_OUT]}}};
        next_sat[p] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < LANES; p++) acc[p] <= '0;
      acc_sat   <= '0;
      grp_open  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (vld_pipe[S]) begin
        for (int p = 0; p < LANES; p++) acc[p] <= next_acc[p];
        acc_sat  <= next_sat;
        grp_open <= !last_pipe[S];
        if (last_pipe[S]) begin
          out_valid <= 1'b1;
          out_sat   <= next_sat;
          for (int p = 0; p < LANES; p++) begin
            data_out[p*WIDTH_OUT +: WIDTH_OUT] <= next_acc[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_in_acc_tree.sv
// Directed bench for channel_in_acc_tree at CH_IN=16, LANES=2, WIDTH_IN=16, WIDTH_OUT=24.
module tb_channel_in_acc_tree;

  localparam int CH_IN = 16;
  localparam int LANES = 2;
  localparam int WI    = 16;
  localparam int WO    = 24;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_first;
  logic                      in_last;
  logic [LANES*CH_IN*WI-1:0] data_in;
  logic                      out_valid;
  logic [LANES*WO-1:0]       data_out;
  logic [LANES-1:0]          out_sat;

  channel_in_acc_tree #(.CH_IN(CH_IN), .LANES(LANES), .WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(data_in), .out_valid(out_valid), .data_out(data_out), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int q0 [$];
  int q1 [$];
  int qs [$];
  int qc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      q0.push_back(int'($signed(data_out[WO-1:0])));
      q1.push_back(int'($signed(data_out[2*WO-1:WO])));
      qs.push_back(int'(out_sat));
      qc.push_back(cyc);
      n_pulse++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic beat(input int v0, input int v1, input logic f, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    for (int c = 0; c < CH_IN; c++) begin
      data_in[(c*LANES)*WI +: WI]   = WI'(v0);
      data_in[(c*LANES+1)*WI +: WI] = WI'(v1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b1;
      in_last  = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pops the next recorded result; a missing result counts as a failure.
  task automatic get_out(input string tag, output int l0, output int l1, output int sat, output int c);
    int k = 0;
    while (q0.size() == 0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (q0.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
      l0 = 0; l1 = 0; sat = 0; c = 0;
    end else begin
      l0 = q0.pop_front(); l1 = q1.pop_front(); sat = qs.pop_front(); c = qc.pop_front();
    end
  endtask

  task automatic run_group(input int n, input int v);
    for (int i = 0; i < n; i++) beat(v, v, i == 0, i == n - 1);
    idle(10);
  endtask

  task automatic expect_group(input string tag, input int n, input int v, input int e, input int es);
    int l0, l1, s, c;
    int base = n_pulse;
    run_group(n, v);
    check({tag, "_pulses"}, n_pulse - base, 1);
    get_out(tag, l0, l1, s, c);
    check({tag, "_lane0"}, l0, e);
    check({tag, "_lane1"}, l1, e);
    check({tag, "_sat"}, s, es);
  endtask

  initial begin
    int l0, l1, s, c, c2, lat, base;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_data", data_out, 0);
    check("reset_sat", out_sat, 0);
    rst = 1'b0;

    // Single-beat group with latency measurement from the capture edge.
    beat(1, -2, 1'b1, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = i;
    end
    check("latency", lat, 5);
    get_out("single", l0, l1, s, c);
    check("single_lane0", l0, 16);
    check("single_lane1", l1, -32);
    check("single_sat", s, 0);
    idle(4);

    // Three beats with two idle cycles between them; idle flags must be ignored.
    base = n_pulse;
    beat(100, 0, 1'b1, 1'b0); idle(2);
    beat(200, 1, 1'b0, 1'b0); idle(2);
    beat(-50, 2, 1'b0, 1'b1); idle(10);
    check("three_pulses", n_pulse - base, 1);
    get_out("three", l0, l1, s, c);
    check("three_lane0", l0, 4000);
    check("three_lane1", l1, 48);

    // Saturation boundaries.
    expect_group("pos16", 16, 32767, 8388352, 0);
    expect_group("pos17", 17, 32767, 8388607, 3);
    expect_group("neg16", 16, -32768, -8388608, 0);
    expect_group("neg17", 17, -32768, -8388608, 3);

    // After clamping, the next beat continues from the clamped value.
    base = n_pulse;
    for (int i = 0; i < 17; i++) beat(32767, 32767, i == 0, 1'b0);
    beat(-1, -1, 1'b0, 1'b1);
    idle(10);
    check("resume_pulses", n_pulse - base, 1);
    get_out("resume", l0, l1, s, c);
    check("resume_lane0", l0, 8388591);
    check("resume_sat", s, 3);

    // Back-to-back single-beat groups.
    beat(3, 3, 1'b1, 1'b1);
    beat(5, 5, 1'b1, 1'b1);
    idle(10);
    get_out("b2b_a", l0, l1, s, c);
    check("b2b_a_lane0", l0, 48);
    get_out("b2b_b", l0, l1, s, c2);
    check("b2b_b_lane0", l0, 80);
    check("b2b_consecutive", c2 - c, 1);

    // Reset mid-group discards it.
    base = n_pulse;
    beat(7, 7, 1'b1, 1'b0);
    beat(7, 7, 1'b0, 1'b0);
    do_reset();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", data_out, 0);
    beat(1, 1, 1'b1, 1'b1);
    idle(10);
    check("midrst_pulses", n_pulse - base, 1);
    get_out("midrst", l0, l1, s, c);
    check("midrst_lane0", l0, 16);

    // Missing first after reset opens a group.
    do_reset();
    beat(2, 2, 1'b0, 1'b1);
    idle(10);
    get_out("nofirst", l0, l1, s, c);
    check("nofirst_lane0", l0, 32);

    // A new first while a group is open drops the old group.
    base = n_pulse;
    beat(9, 9, 1'b1, 1'b0);
    beat(4, 4, 1'b1, 1'b1);
    idle(10);
    check("refirst_pulses", n_pulse - base, 1);
    get_out("refirst", l0, l1, s, c);
    check("refirst_lane1", l1, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_in_acc_tree.md
Name: channel_in_acc_tree

Overview:
- Parametrised successor of the fixed 16-input SIMD channel adder tree.
- Reduces CH_IN input-channel partial products per lane through a registered binary tree with full-precision width growth.
- Accumulates successive tree results across multiple input-channel groups, delimited by first/last flags, with saturation.
- Emits one valid result per group.
- Sits between the PE multiplier array and the bias/quantisation stage.

Parameters:
- CH_IN, 16, input channels reduced per beat; power of two, ≥2.
- LANES, 8, parallel pictures/pixels per channel (SIMD lanes).
- WIDTH_IN, 32, signed width of one lane product.
- WIDTH_OUT, 40, signed accumulator/output width per lane; ≥ WIDTH_IN+log2(CH_IN).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in beat valid; no backpressure.
- in_first  in  1  beat opens a new accumulation group.
- in_last  in  1  beat closes the group; result is emitted.
- data_in  in  LANES*CH_IN*WIDTH_IN  channel c at [(c+1)*LANES*WIDTH_IN-1 : c*LANES*WIDTH_IN]; lane p of that channel at offset p*WIDTH_IN.
- out_valid  out  1  one-cycle pulse per closed group.
- data_out  out  LANES*WIDTH_OUT  lane p at [(p+1)*WIDTH_OUT-1 : p*WIDTH_OUT], signed.
- out_sat  out  LANES  per-lane flag: saturation occurred in this group.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, data_out=0, out_sat=0, all pipeline valid bits=0, group-open flag=0, accumulators=0. Reset mid-group discards the group entirely; no output is produced for it.
- Tree:
  - S=log2(CH_IN) registered stages.
  - Stage s adds adjacent nodes 2i and 2i+1 of stage s-1 (stage 0 = input channels), lane-wise.
  - Stage s node width is WIDTH_IN+s+1, sign-extended, so no overflow occurs inside the tree.
  - Valid/first/last travel in a shift register alongside the data.
  - Data registers update every cycle regardless of valid.
- Accumulator stage (1 register), evaluated when the stage-S valid is set:
  - if first, or no group is open: acc = sign-extended tree sum; sat flags = 0; group open.
  - else: acc = sat(acc + tree sum) to the WIDTH_OUT signed range [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]. A lane's sat flag sets (sticky) when clamping occurs.
  - if last: out_valid=1; data_out = new acc value; out_sat = new flags; group closes.
  - first & last on the same beat: single-beat group; output = tree sum.
- When stage-S valid=0: acc and flags hold, out_valid=0.
- data_out/out_sat hold their last emitted value between pulses.
- Latency: in_valid&in_last sampled at edge T → out_valid high in the cycle after edge T+S+1 (CH_IN=16: 5 clocks). Throughput: one beat per clock. Back-to-back groups (last then first on the next cycle) produce back-to-back outputs.
- in_first while a group is open: the old group is dropped without output and the new group starts.
- in_first/in_last are ignored when in_valid=0.
- Saturation must not wrap; after clamping, later additions continue from the clamped value.

Test Plan:
- Parameters for the bench: CH_IN=16, LANES=2, WIDTH_IN=16, WIDTH_OUT=24.
- Single beat, first&last, every channel lane0=1, lane1=-2 → 5 clocks later out_valid pulse; lane0=16, lane1=-32; out_sat=0.
- 3-beat group, per-channel lane0 values 100, 200, -50 with gaps (in_valid low 2 cycles between beats) → exactly one out_valid; lane0=4000; no output on intermediate beats.
- Saturation: all inputs 32767 (tree sum 524272). Group of 16 beats → 8388352, out_sat=0. Group of 17 beats → 8388607, out_sat=1. Repeat with -32768: 16 beats → -8388608 exactly, out_sat=0; 17 beats → clamped -8388608, out_sat=1.
- Back-to-back: two single-beat groups on consecutive clocks (values 3, then 5) → out_valid on two consecutive cycles with 48, then 80.
- Reset mid-group: 2 beats of value 7, rst high 1 cycle, then a single first&last beat of 1s → out_valid never rises for the aborted group; next output 16; out_valid=0 and data_out=0 right after reset.
- Missing first: beat with in_valid&in_last, no in_first, after reset, value 2 → treated as group start; output 32.
